// File: rtl/cnna_burst_addr_gen_if.sv
// Request and burst-descriptor channels of the cnna burst address generator.
// The requester drives through master; the generator sits on slave.
interface cnna_burst_addr_gen_if #(
    parameter int ADDR_W = 35,
    parameter int LEN_W  = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_row;
    logic [26:0]       req_stride;
    logic [ADDR_W-1:0] req_base;
    logic [LEN_W-1:0]  req_beats;

    logic              bst_valid;
    logic              bst_ready;
    logic [ADDR_W-1:0] bst_addr;
    logic [7:0]        bst_len;
    logic              bst_last;

    modport master (
        output req_valid, req_row, req_stride,
        output req_base, req_beats,
        input  req_ready,
        input  bst_valid, bst_addr, bst_len, bst_last,
        output bst_ready
    );

    modport slave (
        input  req_valid, req_row, req_stride,
        input  req_base, req_beats,
        output req_ready,
        output bst_valid, bst_addr, bst_len, bst_last,
        input  bst_ready
    );
endinterface

// File: rtl/cnna_burst_addr_gen.sv
// Turns base + row*stride requests into burst descriptors that are
// capped at MAX_BURST beats and never straddle a BOUND_BYTES boundary.
module cnna_burst_addr_gen #(
    parameter int ADDR_W      = 35,
    parameter int LEN_W       = 16,
    parameter int BEAT_BYTES  = 8,
    parameter int MAX_BURST   = 16,
    parameter int BOUND_BYTES = 4096
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    cnna_burst_addr_gen_if.slave  bus,
    output logic                  busy
);
    localparam int BB_W  = $clog2(BEAT_BYTES);
    localparam int OFF_W = $clog2(BOUND_BYTES);
    localparam int CW    = (LEN_W > OFF_W + 1) ? LEN_W : OFF_W + 1;

    localparam logic [CW-1:0]     MAXB  = CW'(MAX_BURST);
    localparam logic [OFF_W:0]    BOUND = (OFF_W + 1)'(BOUND_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ADD,
        S_EMIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_rdy;
    logic [7:0]        r_row;
    logic [26:0]       r_stride;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_beats;
    logic [ADDR_W-1:0] r_prod;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;

    logic              w_fire_req;
    logic              w_fire_bst;
    logic              w_emit;
    logic [ADDR_W-1:0] w_prod;
    logic [OFF_W:0]    w_room;
    logic [CW-1:0]     w_cap;
    logic [CW-1:0]     w_n;
    logic              w_last;

    assign w_emit     = (r_state == S_EMIT);
    assign w_fire_req = bus.req_valid & bus.req_ready;
    assign w_fire_bst = w_emit & bus.bst_ready;

    // 8 x 27 bits fills ADDR_W exactly, so nothing is lost here
    assign w_prod = ADDR_W'(r_row) * ADDR_W'(r_stride);

    // Beats left before the next boundary; never zero as r_addr is aligned
    assign w_room = (BOUND - {1'b0, r_addr[OFF_W-1:0]}) >> BB_W;
    assign w_cap  = (CW'(r_rem) < MAXB) ? CW'(r_rem) : MAXB;
    assign w_n    = (CW'(w_room) < w_cap) ? CW'(w_room) : w_cap;
    assign w_last = (w_n == CW'(r_rem));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        bus.bst_valid = 1'b0;
        bus.bst_len   = '0;
        bus.bst_last  = 1'b0;
        busy          = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy          = 1'b0;
                bus.req_ready = r_rdy;
                if (w_fire_req) begin
                    w_next = S_MUL;
                end
            end
            S_MUL: begin
                w_next = S_ADD;
            end
            S_ADD: begin
                w_next = (r_beats == '0) ? S_IDLE : S_EMIT;
            end
            S_EMIT: begin
                bus.bst_valid = 1'b1;
                bus.bst_len   = 8'(w_n - CW'(1));
                bus.bst_last  = w_last;
                if (w_fire_bst && w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.bst_addr = r_addr;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rdy    <= 1'b0;
            r_row    <= '0;
            r_stride <= '0;
            r_base   <= '0;
            r_beats  <= '0;
            r_prod   <= '0;
            r_addr   <= '0;
            r_rem    <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_fire_req) begin
                r_row    <= bus.req_row;
                r_stride <= bus.req_stride;
                r_base   <= bus.req_base;
                r_beats  <= bus.req_beats;
            end
            if (r_state == S_MUL) begin
                r_prod <= w_prod;
            end
            if (r_state == S_ADD) begin
                r_addr <= (r_base + r_prod) & ALIGN;
                r_rem  <= r_beats;
            end
            if (w_fire_bst) begin
                r_addr <= r_addr + (ADDR_W'(w_n) << BB_W);
                r_rem  <= r_rem - LEN_W'(w_n);
            end
        end
    end
endmodule

// File: tb/tb_cnna_burst_addr_gen.sv
// Randomised bench for cnna_burst_addr_gen with a queue-based burst model
// and literal expectations for the directed address/split scenarios.
module tb_cnna_burst_addr_gen;
    localparam int AW = 35;
    localparam int LW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic          last;
    } desc_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic busy;

    cnna_burst_addr_gen_if #(.ADDR_W(AW), .LEN_W(LW)) bus ();

    cnna_burst_addr_gen #(
        .ADDR_W(AW), .LEN_W(LW), .BEAT_BYTES(8),
        .MAX_BURST(16), .BOUND_BYTES(4096)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bus.slave),
        .busy    (busy)
    );

    always #5 ap_clk = ~ap_clk;

    int    cyc = 0;
    int    checks = 0;
    int    passes = 0;
    int    first_cyc = 0;
    int    ready_from = 1 << 30;
    bit    rst_rel = 1'b1;
    int    rmode = 0;
    desc_t exp_q[$];
    desc_t obs_q[$];

    always @(posedge ap_clk) cyc++;

    function automatic void chk(input string nm,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h (cycle %0d)",
                      nm, act, exp, cyc);
    endfunction

    // Expected descriptors from the request, by plain arithmetic
    function automatic void model_req(input logic [7:0] row,
                                      input logic [26:0] stride,
                                      input logic [AW-1:0] base,
                                      input logic [LW-1:0] beats);
        longint unsigned p, a, m;
        int rem, n, room;
        m = 64'd1 << AW;
        p = 64'(row) * 64'(stride);
        a = (64'(base) + p) % m;
        a = a - (a % 8);
        rem = int'(beats);
        while (rem > 0) begin
            room = (4096 - int'(a % 4096)) / 8;
            n = (rem < 16) ? rem : 16;
            if (room < n) n = room;
            exp_q.push_back('{addr: AW'(a), len: 8'(n - 1),
                              last: (n == rem)});
            a = (a + 64'(n * 8)) % m;
            rem -= n;
        end
    endfunction

    always @(negedge ap_clk) begin
        bit exp_rdy;
        bit exp_v;
        if (!ap_rst_n) begin
            exp_q.delete();
            ready_from = cyc + 2;
            rst_rel = 1'b1;
            chk("rst_bst_valid", 64'(bus.bst_valid), 64'd0);
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_bst_addr", 64'(bus.bst_addr), 64'd0);
            chk("rst_bst_len", 64'(bus.bst_len), 64'd0);
            chk("rst_bst_last", 64'(bus.bst_last), 64'd0);
        end else begin
            exp_rdy = (cyc >= ready_from);
            chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(!exp_rdy && !rst_rel));
            exp_v = (exp_q.size() > 0) && (cyc >= first_cyc);
            chk("bst_valid", 64'(bus.bst_valid), 64'(exp_v));
            if (bus.bst_valid && exp_q.size() > 0) begin
                chk("bst_addr", 64'(bus.bst_addr), 64'(exp_q[0].addr));
                chk("bst_len", 64'(bus.bst_len), 64'(exp_q[0].len));
                chk("bst_last", 64'(bus.bst_last), 64'(exp_q[0].last));
                if (bus.bst_ready) begin
                    if (exp_q[0].last) ready_from = cyc + 1;
                    void'(exp_q.pop_front());
                end
            end
            if (bus.bst_valid && bus.bst_ready)
                obs_q.push_back('{addr: bus.bst_addr, len: bus.bst_len,
                                  last: bus.bst_last});
            if (bus.req_valid && exp_rdy) begin
                model_req(bus.req_row, bus.req_stride,
                          bus.req_base, bus.req_beats);
                first_cyc = cyc + 3;
                rst_rel = 1'b0;
                ready_from = (bus.req_beats == '0) ? cyc + 3 : (1 << 30);
            end
        end
    end

    always @(posedge ap_clk) begin
        #1;
        if (rmode == 0) bus.bst_ready = 1'b1;
        else if (rmode == 1) bus.bst_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] row, input logic [26:0] stride,
                        input logic [AW-1:0] base, input logic [LW-1:0] beats);
        int k = 0;
        while (!bus.req_ready && k < 3000) begin
            tick();
            k++;
        end
        if (k >= 3000) chk("send_timeout", 64'd1, 64'd0);
        bus.req_valid  = 1'b1;
        bus.req_row    = row;
        bus.req_stride = stride;
        bus.req_base   = base;
        bus.req_beats  = beats;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(bus.req_ready && !busy && exp_q.size() == 0) && k < 3000) begin
            tick();
            k++;
        end
        if (k >= 3000) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.bst_valid && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) chk("valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic expect_n(input string nm, input int n);
        chk({nm, "_count"}, 64'(obs_q.size()), 64'(n));
    endtask

    task automatic expect_d(input string nm, input int i,
                            input logic [AW-1:0] a, input logic [7:0] l,
                            input logic t);
        desc_t want;
        want = '{addr: a, len: l, last: t};
        if (i < obs_q.size()) chk(nm, 64'(obs_q[i]), 64'(want));
        else chk(nm, 64'hdead, 64'(want));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not finish, got timeout want done");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_row    = '0;
        bus.req_stride = '0;
        bus.req_base   = '0;
        bus.req_beats  = '0;
        bus.bst_ready  = 1'b1;
        repeat (3) tick();
        ap_rst_n = 1'b1;
        tick();

        rmode = 0;
        obs_q.delete();
        send(8'd2, 27'h100, 35'h1000, 16'd4);
        wait_idle();
        expect_n("simple", 1);
        expect_d("simple_d0", 0, 35'h1200, 8'd3, 1'b1);

        obs_q.delete();
        send(8'd0, 27'h123, 35'h0, 16'd40);
        wait_idle();
        expect_n("split", 3);
        expect_d("split_d0", 0, 35'h000, 8'd15, 1'b0);
        expect_d("split_d1", 1, 35'h080, 8'd15, 1'b0);
        expect_d("split_d2", 2, 35'h100, 8'd7, 1'b1);

        obs_q.delete();
        send(8'd0, 27'h55, 35'hFE0, 16'd10);
        wait_idle();
        expect_n("cross4k", 2);
        expect_d("cross4k_d0", 0, 35'hFE0, 8'd3, 1'b0);
        expect_d("cross4k_d1", 1, 35'h1000, 8'd5, 1'b1);

        obs_q.delete();
        send(8'd255, 27'h7FFFFFF, 35'h0, 16'd1);
        wait_idle();
        expect_d("wide_prod", 0, 35'h7F7FFFF00, 8'd0, 1'b1);

        obs_q.delete();
        send(8'd1, 27'd8, 35'h7FFFFFFF8, 16'd2);
        wait_idle();
        expect_d("wrap_zero", 0, 35'h0, 8'd1, 1'b1);

        obs_q.delete();
        send(8'd3, 27'h40, 35'h500, 16'd0);
        wait_idle();
        expect_n("zero_len", 0);

        rmode = 2;
        bus.bst_ready = 1'b0;
        obs_q.delete();
        send(8'd0, 27'd0, 35'h3000, 16'd20);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            bus.req_valid  = 1'b1;
            bus.req_base   = 35'h7000;
            bus.req_beats  = 16'd3;
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_hold_addr", 64'(bus.bst_addr), 64'h3000);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.bst_ready = 1'b1;
        wait_idle();
        expect_n("bp", 2);
        expect_d("bp_d0", 0, 35'h3000, 8'd15, 1'b0);
        expect_d("bp_d1", 1, 35'h3080, 8'd3, 1'b1);

        bus.bst_ready = 1'b0;
        send(8'd0, 27'd0, 35'h0, 16'd40);
        wait_valid();
        bus.bst_ready = 1'b1;
        tick();
        bus.bst_ready = 1'b0;
        tick();
        ap_rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.bst_valid), 64'd0);
        tick();
        tick();
        ap_rst_n = 1'b1;
        rmode = 0;
        obs_q.delete();
        send(8'd0, 27'd0, 35'h2000, 16'd1);
        wait_idle();
        expect_n("post_rst", 1);
        expect_d("post_rst_d0", 0, 35'h2000, 8'd0, 1'b0 + 1'b1);

        rmode = 1;
        for (int r = 0; r < 40; r++) begin
            logic [AW-1:0] b;
            logic [LW-1:0] n;
            b = AW'({$urandom(), $urandom()});
            case ($urandom_range(0, 3))
                0: b[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
                1: b = {8'hFF, b[26:0]};
                default: ;
            endcase
            n = LW'($urandom_range(0, 200));
            send(8'($urandom()), 27'($urandom()), b, n);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 3; j++) begin
                    bus.req_valid  = 1'b1;
                    bus.req_row    = 8'($urandom());
                    bus.req_stride = 27'($urandom());
                    bus.req_base   = AW'({$urandom(), $urandom()});
                    bus.req_beats  = LW'($urandom_range(0, 63));
                    tick();
                end
                bus.req_valid = 1'b0;
            end
            wait_idle();
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/cnna_burst_addr_gen.md
Name: cnna_burst_addr_gen

Overview:
- Downstream consumer of the 8-bit × 27-bit unsigned row-offset product (35-bit) in the cnna datapath.
- Per request, forms start address = base + row × stride, then splits the request's beat count into AXI-style read/write bursts.
- Bursts are capped by MAX_BURST and never cross a 4 KB boundary.
- Feeds the memory-master address channel; one request in flight at a time.

Parameters:
- ADDR_W, 35, address width; equals product width.
- LEN_W, 16, width of request beat count.
- BEAT_BYTES, 8, bytes per data beat; power of two.
- MAX_BURST, 16, maximum beats per burst; power of two, ≤256.
- BOUND_BYTES, 4096, burst must not cross a multiple of this.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accept; high only in IDLE.
- req_row  in  8  row index, unsigned.
- req_stride  in  27  bytes per row, unsigned.
- req_base  in  ADDR_W  region base byte address.
- req_beats  in  LEN_W  total beats to transfer.
- bst_valid  out  1  burst descriptor valid.
- bst_ready  in  1  downstream accepts descriptor.
- bst_addr  out  ADDR_W  burst start byte address, beat-aligned.
- bst_len  out  8  beats in burst minus 1.
- bst_last  out  1  descriptor is final burst of request.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; req_ready=0 while reset is asserted, 1 from the first cycle after release; bst_valid=0; bst_addr=0; bst_len=0; bst_last=0; busy=0; internal registers zeroed.
- Request accepted on a cycle where req_valid & req_ready. All request fields are captured that cycle.
- FSM:
  - IDLE -> MUL on accept.
  - MUL: registers product = req_row × req_stride, unsigned, full 35 bits, no truncation. -> ADD.
  - ADD: addr = (base + product) mod 2^ADDR_W; low log2(BEAT_BYTES) bits forced to 0; remaining = beats.
    - remaining = 0: -> IDLE, no descriptor issued.
    - Otherwise: -> EMIT.
  - EMIT: bst_valid=1.
- Burst length:
  - n = min(remaining, MAX_BURST, (BOUND_BYTES − addr mod BOUND_BYTES)/BEAT_BYTES); n ≥ 1 always.
  - bst_len = n−1.
  - bst_last = (n == remaining).
- Latency: accept at cycle T -> first bst_valid at T+3.
- Handshake: bst_valid & bst_ready in cycle t:
  - addr += n×BEAT_BYTES (mod 2^ADDR_W); remaining −= n.
  - If last: -> IDLE, req_ready=1 at t+1.
  - Else: next descriptor valid at t+1, with no bubble.
- Backpressure: while bst_valid & !bst_ready, bst_addr/bst_len/bst_last hold stable; bst_valid never drops without a handshake.
- Address wrap at 2^ADDR_W is silent modulo arithmetic, no error. A wrap landing at 0 is a 4 KB boundary.
- req_valid in non-IDLE states is ignored; the request is not consumed.
- Reset mid-request: all state discarded immediately; no further descriptors for that request.

Test Plan:
- Simple: row=2, stride=0x100, base=0x1000, beats=4 -> at T+3, single descriptor addr=0x1200, len=3, last=1; req_ready=1 the cycle after the handshake.
- MAX_BURST split, bst_ready tied 1: row=0, base=0x0, beats=40 -> addr 0x000 len15 last0; 0x080 len15 last0; 0x100 len7 last1, on consecutive cycles.
- 4 KB crossing: base=0xFE0, row=0, beats=10 -> 0xFE0 len3 last0; 0x1000 len5 last1.
- Width/wrap:
  - row=255, stride=0x7FFFFFF, base=0, beats=1 -> addr=0x7F7FFFF00 (product 0x7F7FFFF01, low bits cleared), len0 last1.
  - base=0x7FFFFFFF8, row=1, stride=8, beats=2 -> addr=0x0, len1 last1.
- Backpressure and zero-length:
  - bst_ready low 5 cycles on the first of two bursts -> outputs stable, req_ready=0, a second req_valid is not accepted.
  - beats=0 -> no descriptor, req_ready=1 at T+3.
- Reset mid-request: assert ap_rst_n=0 between the first and second descriptors of a beats=40 request -> bst_valid=0 immediately. After release, a new request (base=0x2000, beats=1) yields exactly one descriptor, 0x2000 len0 last1.
